// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if
//   Bundles the map state published by game_core and the LED matrix drive
//   produced by led_matrix_scanner.
//   Map side (driven by master):
//     wall, box, destination : 64-bit bitmaps, cell index = row*8+col
//     man                    : 6-bit man cell index
//     win                    : level-complete flag
//   Display side (driven by slave):
//     row_sel     : one-hot row enable, bit r = row r
//     col_red     : red column drive, bit c = column c
//     col_green   : green column drive
//     frame_start : one-cycle pulse in the first cycle of each frame
//     blink       : debug view of the blink phase (1 = visible phase)
//   There is no handshake: the map is a level-valued bus that the scanner
//   samples once per frame, and the display outputs are free-running.
interface led_matrix_scanner_if;
  logic [63:0] wall;
  logic [63:0] box;
  logic [63:0] destination;
  logic [5:0]  man;
  logic        win;
  logic [7:0]  row_sel;
  logic [7:0]  col_red;
  logic [7:0]  col_green;
  logic        frame_start;
  logic        blink;

  modport master (
    output wall, box, destination, man, win,
    input  row_sel, col_red, col_green, frame_start, blink
  );

  modport slave (
    input  wall, box, destination, man, win,
    output row_sel, col_red, col_green, frame_start, blink
  );
endinterface

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//   Drives a row-multiplexed 8x8 red/green LED matrix from the Sokoban map.
//   The map is snapshotted once per frame (on the last cycle of row 7) so a
//   frame never tears. Each row is held ROW_DIV cycles; the first BLANK
//   cycles of each row keep the columns dark to avoid ghosting. The man and
//   uncovered destinations blink with a half-period of BLINK_FRAMES frames.
//   Ports:
//     clk : system clock
//     rst : synchronous active-high reset
//     bus : led_matrix_scanner_if.slave (map in, display out)
module led_matrix_scanner #(
  parameter int ROW_DIV      = 1024,
  parameter int BLANK        = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  led_matrix_scanner_if.slave   bus
);

  localparam int DIV_W = (ROW_DIV > 2) ? $clog2(ROW_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(ROW_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_C = DIV_W'(BLANK);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       row_q, row_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             blink_q, blink_d;
  logic [63:0]      wall_s_q, wall_s_d;
  logic [63:0]      box_s_q, box_s_d;
  logic [63:0]      dest_s_q, dest_s_d;
  logic [5:0]       man_s_q, man_s_d;
  logic             win_s_q, win_s_d;
  logic             fs_q, fs_d;

  // Next-state: the row divider rolls the row counter, and the row 7 roll
  // is the frame boundary where the map is captured and blink advances.
  always_comb begin
    div_d    = div_q + DIV_W'(1);
    row_d    = row_q;
    frm_d    = frm_q;
    blink_d  = blink_q;
    wall_s_d = wall_s_q;
    box_s_d  = box_s_q;
    dest_s_d = dest_s_q;
    man_s_d  = man_s_q;
    win_s_d  = win_s_q;
    fs_d     = 1'b0;
    if (div_q == DIV_MAX) begin
      div_d = '0;
      row_d = row_q + 3'd1;
      if (row_q == 3'd7) begin
        wall_s_d = bus.wall;
        box_s_d  = bus.box;
        dest_s_d = bus.destination;
        man_s_d  = bus.man;
        win_s_d  = bus.win;
        fs_d     = 1'b1;
        if (frm_q == FRM_MAX) begin
          frm_d   = '0;
          blink_d = ~blink_q;
        end else begin
          frm_d = frm_q + FRM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      row_q    <= '0;
      frm_q    <= '0;
      blink_q  <= 1'b1;
      wall_s_q <= '0;
      box_s_q  <= '0;
      dest_s_q <= '0;
      man_s_q  <= '0;
      win_s_q  <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      row_q    <= row_d;
      frm_q    <= frm_d;
      blink_q  <= blink_d;
      wall_s_q <= wall_s_d;
      box_s_q  <= box_s_d;
      dest_s_q <= dest_s_d;
      man_s_q  <= man_s_d;
      win_s_q  <= win_s_d;
      fs_q     <= fs_d;
    end
  end

  // Column decode works purely from registered state, so the LED drive
  // never sees a combinational path from the live map inputs.
  logic [7:0] red_c, green_c;
  logic [5:0] idx;
  logic       lit, r_c, g_c;

  always_comb begin
    red_c   = '0;
    green_c = '0;
    idx     = '0;
    lit     = 1'b0;
    r_c     = 1'b0;
    g_c     = 1'b0;
    if (div_q >= BLANK_C) begin
      for (int c = 0; c < 8; c++) begin
        idx = {row_q, 3'(c)};
        r_c = 1'b0;
        g_c = 1'b0;
        // Priority: man, placed box, box, wall, empty destination.
        if (idx == man_s_q) begin
          r_c = blink_q;
          g_c = blink_q;
        end else if (box_s_q[idx] && dest_s_q[idx]) begin
          r_c = 1'b1;
          g_c = 1'b1;
        end else if (box_s_q[idx]) begin
          g_c = 1'b1;
        end else if (wall_s_q[idx]) begin
          r_c = 1'b1;
        end else if (dest_s_q[idx]) begin
          g_c = blink_q;
        end
        lit = (idx == man_s_q) | box_s_q[idx] | wall_s_q[idx] | dest_s_q[idx];
        // On a win every occupied cell glows solid green.
        if (win_s_q) begin
          r_c = 1'b0;
          g_c = lit;
        end
        red_c[c]   = r_c;
        green_c[c] = g_c;
      end
    end
  end

  assign bus.row_sel     = 8'b1 << row_q;
  assign bus.col_red     = red_c;
  assign bus.col_green   = green_c;
  assign bus.frame_start = fs_q;
  assign bus.blink       = blink_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner
//   Self-checking bench for led_matrix_scanner with ROW_DIV=8, BLANK=2,
//   BLINK_FRAMES=2. The reference model tracks time since reset and derives
//   row, divider phase, frame number and blink phase arithmetically; the
//   map it displays is the one captured at the end of each frame.
module tb_led_matrix_scanner;
  localparam int RD  = 8;
  localparam int BL  = 2;
  localparam int BF  = 2;
  localparam int FRM = 8 * RD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_matrix_scanner_if bus ();

  led_matrix_scanner #(.ROW_DIV(RD), .BLANK(BL), .BLINK_FRAMES(BF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: cycles since reset release plus the captured map.
  int          t = 0;
  logic [63:0] m_wall = '0, m_box = '0, m_dest = '0;
  logic [5:0]  m_man = '0;
  logic        m_win = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  function automatic void exp_cols(input int row, input int div, input bit bl,
                                   output logic [7:0] r, output logic [7:0] g);
    int  i;
    bit  lit, rr, gg;
    r = '0;
    g = '0;
    if (div < BL) return;
    for (int c = 0; c < 8; c++) begin
      i  = row * 8 + c;
      rr = 1'b0;
      gg = 1'b0;
      if (i == int'(m_man))              begin rr = bl;   gg = bl;   end
      else if (m_box[i] && m_dest[i])    begin rr = 1'b1; gg = 1'b1; end
      else if (m_box[i])                 gg = 1'b1;
      else if (m_wall[i])                rr = 1'b1;
      else if (m_dest[i])                gg = bl;
      lit = (i == int'(m_man)) || m_box[i] || m_wall[i] || m_dest[i];
      if (m_win) begin rr = 1'b0; gg = lit; end
      r[c] = rr;
      g[c] = gg;
    end
  endfunction

  // One clock: update the model on the edge, then check every output.
  task automatic cyc();
    int row, div, f;
    bit bl;
    logic [7:0] er, eg;
    @(posedge clk);
    if (rst) begin
      t = 0;
      m_wall = '0; m_box = '0; m_dest = '0; m_man = '0; m_win = 1'b0;
    end else begin
      if (t % FRM == FRM - 1) begin
        m_wall = bus.wall; m_box = bus.box; m_dest = bus.destination;
        m_man  = bus.man;  m_win = bus.win;
      end
      t++;
    end
    #1;
    row = (t / RD) % 8;
    div = t % RD;
    f   = t / FRM;
    bl  = ((f / BF) % 2) == 0;
    exp_cols(row, div, bl, er, eg);
    check("row_sel",     32'(bus.row_sel),     32'(8'b1 << row));
    check("col_red",     32'(bus.col_red),     32'(er));
    check("col_green",   32'(bus.col_green),   32'(eg));
    check("frame_start", 32'(bus.frame_start), 32'((t != 0) && (t % FRM == 0)));
    check("blink",       32'(bus.blink),       32'(bl));
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (t != target && guard < 5000) begin
      cyc();
      guard++;
    end
    check("run_to_reached", 32'(t), 32'(target));
  endtask

  initial begin
    bus.wall = '0; bus.box = '0; bus.destination = '0; bus.man = '0; bus.win = 1'b0;

    // Reset held for a few cycles.
    rst = 1'b1;
    repeat (3) cyc();
    check("reset_row_sel", 32'(bus.row_sel), 32'h01);
    check("reset_cols",    32'({bus.col_red, bus.col_green}), 32'h0);
    rst = 1'b0;

    // Test 1 + 2: first frame dark, then a row-0 wall with man at cell 63.
    run_to(10);
    bus.wall = 64'h00000000000000FF; bus.man = 6'd63;
    run_to(64);
    check("t2_frame_start", 32'(bus.frame_start), 32'h1);
    run_to(66);
    check("t2_row0_red",   32'(bus.col_red),   32'hFF);
    check("t2_row0_green", 32'(bus.col_green), 32'h00);
    run_to(122);
    check("t2_row7_red_vis",   32'(bus.col_red),   32'h80);
    check("t2_row7_green_vis", 32'(bus.col_green), 32'h80);
    run_to(150);
    bus.wall = '0;
    bus.box = (64'h1 << 9) | (64'h1 << 10);
    bus.destination = (64'h1 << 10) | (64'h1 << 11);
    bus.man = 6'd0;
    run_to(186);
    check("t2_row7_red_dark",   32'(bus.col_red),   32'h00);
    check("t2_row7_green_dark", 32'(bus.col_green), 32'h00);

    // Test 3: boxes and destinations in row 1.
    run_to(203);
    check("t3_row1_green_dark", 32'(bus.col_green), 32'h06);
    check("t3_row1_red_dark",   32'(bus.col_red),   32'h04);
    run_to(267);
    check("t3_row1_green_vis", 32'(bus.col_green), 32'h0E);
    check("t3_row1_red_vis",   32'(bus.col_red),   32'h04);

    // Test 4: win override.
    run_to(280);
    bus.win = 1'b1;
    run_to(323);
    check("t4_row0_green_vis", 32'(bus.col_green), 32'h01);
    check("t4_row0_red_vis",   32'(bus.col_red),   32'h00);
    run_to(331);
    check("t4_row1_green_vis", 32'(bus.col_green), 32'h0E);
    check("t4_row1_red_vis",   32'(bus.col_red),   32'h00);
    run_to(387);
    check("t4_row0_green_dark", 32'(bus.col_green), 32'h01);
    run_to(395);
    check("t4_row1_green_dark", 32'(bus.col_green), 32'h0E);
    run_to(400);
    bus.win = 1'b0;

    // Test 5: wall changes while row 3 of frame 7 is showing.
    run_to(472);
    bus.wall = 64'hFF00000000000000;
    run_to(507);
    check("t5_old_map_row7_red", 32'(bus.col_red), 32'h00);
    run_to(512);
    check("t5_frame_start", 32'(bus.frame_start), 32'h1);
    run_to(571);
    check("t5_new_map_row7_red", 32'(bus.col_red), 32'hFF);

    // Test 6: reset at row 5, div 4 of frame 9.
    run_to(620);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t6_row_sel",     32'(bus.row_sel),     32'h01);
    check("t6_cols",        32'({bus.col_red, bus.col_green}), 32'h0);
    check("t6_frame_start", 32'(bus.frame_start), 32'h0);
    check("t6_blink",       32'(bus.blink),       32'h1);
    run_to(59);
    check("t6_dark_row7_red", 32'(bus.col_red), 32'h00);

    // Randomized maps with changes at arbitrary points in the frame.
    for (int n = 0; n < 8 * FRM; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0: bus.wall = {$urandom, $urandom};
          1: bus.box = {$urandom, $urandom} & {$urandom, $urandom};
          2: bus.destination = {$urandom, $urandom} & {$urandom, $urandom};
          3: bus.man = 6'($urandom_range(0, 63));
          default: bus.win = ($urandom_range(0, 3) == 0);
        endcase
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
